elevator_ctrl_3f: RTL and testbench

//  Three-floor (0..2) elevator controller feeding the 7-segment display decoder.

---
 rtl/elevator_ctrl_3f_pkg.sv | 85 ++++++++
 rtl/elevator_ctrl_3f_timer.sv | 30 +++
 rtl/elevator_ctrl_3f.sv | 184 ++++++++++++++++++
 tb/tb_elevator_ctrl_3f.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_ctrl_3f_pkg.sv
// Shared types, display codes and small decode helpers for the three-floor
// elevator controller. The display constants are also what the downstream
// 7-segment decoder expects on {i2,i1,i0}.
`timescale 1ns/1ps
package elevator_ctrl_3f_pkg;

  // Controller states, 3-bit sequential encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UP    = 3'd1,
    ST_DOWN  = 3'd2,
    ST_DOOR  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  // Display codes consumed by the decoder.
  localparam logic [2:0] DISP_F0   = 3'b000;
  localparam logic [2:0] DISP_F1   = 3'b001;
  localparam logic [2:0] DISP_F2   = 3'b010;
  localparam logic [2:0] DISP_UP   = 3'b011;
  localparam logic [2:0] DISP_DN   = 3'b100;
  localparam logic [2:0] DISP_STOP = 3'b111;

  // More than one floor sensor active at once: physically impossible.
  function automatic logic sens_multi(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Exactly one floor sensor active: the car is level with a floor.
  function automatic logic sens_one(input logic [2:0] s);
    return (s == 3'b001) || (s == 3'b010) || (s == 3'b100);
  endfunction

  // Floor index of a one-hot sensor vector (only meaningful when sens_one).
  function automatic logic [1:0] sens_flr(input logic [2:0] s);
    if (s[2])      return 2'd2;
    else if (s[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  // One-hot mask for a floor index.
  function automatic logic [2:0] flr_mask(input logic [1:0] f);
    case (f)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Any pending request strictly above floor f.
  function automatic logic req_above(input logic [2:0] req, input logic [1:0] f);
    case (f)
      2'd0:    return req[1] | req[2];
      2'd1:    return req[2];
      default: return 1'b0;
    endcase
  endfunction

  // Any pending request strictly below floor f.
  function automatic logic req_below(input logic [2:0] req, input logic [1:0] f);
    case (f)
      2'd2:    return req[0] | req[1];
      2'd1:    return req[0];
      default: return 1'b0;
    endcase
  endfunction

  // Display code for a given state and current floor.
  function automatic logic [2:0] disp_for(input state_t st, input logic [1:0] f);
    case (st)
      ST_UP:    return DISP_UP;
      ST_DOWN:  return DISP_DN;
      ST_FAULT: return DISP_STOP;
      default: begin
        case (f)
          2'd0:    return DISP_F0;
          2'd1:    return DISP_F1;
          default: return DISP_F2;
        endcase
      end
    endcase
  endfunction

endpackage

// File: rtl/elevator_ctrl_3f_timer.sv
// Loadable down-counter with a done flag. Load has priority over counting;
// the count parks at zero so done stays asserted until the next load.
`timescale 1ns/1ps
module elev_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  // Count down while enabled, reload on request, hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/elevator_ctrl_3f.sv
// Three-floor elevator controller: latches calls, picks a direction, drives
// the motor, times the door and produces the display code for the decoder.
// All outputs are registered from the next state, so they change on the same
// edge as the state. dbg_state mirrors the FSM state for observation.
//
// Handshake note: there is no valid/ready traffic here; call_btn is a level
// that is folded into the request latch every cycle it is high.
`timescale 1ns/1ps
module elevator_ctrl_3f
  import elevator_ctrl_3f_pkg::*;
#(
  parameter int DOOR_CYCLES = 50_000_000,
  parameter int TRAVEL_MAX  = 200_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] call_btn,
  input  logic [2:0] flr_sens,
  input  logic       door_obst,
  output logic       motor_up,
  output logic       motor_dn,
  output logic       door_open,
  output logic [2:0] disp_code,
  output logic       fault,
  output logic [2:0] dbg_state
);

  localparam int DW = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
  localparam int TW = (TRAVEL_MAX  > 2) ? $clog2(TRAVEL_MAX)  : 1;
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_MAX - 1);

  state_t     state, state_n;
  logic [1:0] cur_flr, flr_n;
  logic [2:0] req;
  logic [2:0] req_clr;
  logic [2:0] req_set;
  logic       arrive;
  logic       moving;
  logic       door_reload;
  logic       door_done;
  logic       travel_done;
  logic       s_one;
  logic [1:0] s_flr;

  assign moving      = (state == ST_UP) || (state == ST_DOWN);
  assign door_reload = (state == ST_DOOR) && (door_obst || call_btn[cur_flr]);
  assign s_one       = sens_one(flr_sens);
  assign s_flr       = sens_flr(flr_sens);
  assign dbg_state   = state;

  // A call at the floor whose door is open only holds the door; it never latches.
  assign req_set = call_btn & ~((state == ST_DOOR) ? flr_mask(cur_flr) : 3'b000);

  // Door timer holds DOOR_CYCLES-1 whenever the door is shut, so entry starts a full period.
  elev_timer #(.W(DW)) u_door_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     ((state != ST_DOOR) || door_reload),
    .load_val (DOOR_LOAD),
    .en       (state == ST_DOOR),
    .done     (door_done)
  );

  // Travel timer restarts at every departure and every floor passed.
  elev_timer #(.W(TW)) u_travel_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (!moving || arrive),
    .load_val (TRAVEL_LOAD),
    .en       (moving),
    .done     (travel_done)
  );

  // Next-state decode: direction choice, floor arrival, door timeout, faults.
  always_comb begin
    state_n = state;
    flr_n   = cur_flr;
    req_clr = 3'b000;
    arrive  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req[cur_flr]) begin
          state_n = ST_DOOR;
          req_clr = flr_mask(cur_flr);
        end else if (req_above(req, cur_flr)) begin
          state_n = ST_UP;
        end else if (req_below(req, cur_flr)) begin
          state_n = ST_DOWN;
        end
      end
      ST_UP: begin
        // The old floor's sensor lingers while the car departs; ignore it.
        if (s_one && (s_flr != cur_flr)) begin
          if (s_flr == cur_flr + 2'd1) begin
            arrive = 1'b1;
            flr_n  = s_flr;
            if (req[s_flr]) begin
              state_n = ST_DOOR;
              req_clr = flr_mask(s_flr);
            end else if (req_above(req, s_flr)) begin
              state_n = ST_UP;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            state_n = ST_FAULT;
          end
        end else if (travel_done) begin
          state_n = ST_FAULT;
        end
      end
      ST_DOWN: begin
        if (s_one && (s_flr != cur_flr)) begin
          if (s_flr == cur_flr - 2'd1) begin
            arrive = 1'b1;
            flr_n  = s_flr;
            if (req[s_flr]) begin
              state_n = ST_DOOR;
              req_clr = flr_mask(s_flr);
            end else if (req_below(req, s_flr)) begin
              state_n = ST_DOWN;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            state_n = ST_FAULT;
          end
        end else if (travel_done) begin
          state_n = ST_FAULT;
        end
      end
      ST_DOOR: begin
        if (!door_reload && door_done) begin
          state_n = ST_IDLE;
        end
      end
      ST_FAULT: begin
        state_n = ST_FAULT;
      end
      default: begin
        state_n = ST_FAULT;
      end
    endcase
    // Conflicting sensors mean the position is unknown, whatever the state.
    if (sens_multi(flr_sens)) begin
      state_n = ST_FAULT;
      flr_n   = cur_flr;
      req_clr = 3'b000;
      arrive  = 1'b0;
    end
  end

  // Request latch: new calls accumulate; servicing a floor clears it and wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      req <= 3'b000;
    end else begin
      req <= (req | req_set) & ~req_clr;
    end
  end

  // FSM state, current floor and all registered outputs, derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_flr   <= 2'd0;
      motor_up  <= 1'b0;
      motor_dn  <= 1'b0;
      door_open <= 1'b0;
      fault     <= 1'b0;
      disp_code <= DISP_F0;
    end else begin
      state     <= state_n;
      cur_flr   <= flr_n;
      motor_up  <= (state_n == ST_UP);
      motor_dn  <= (state_n == ST_DOWN);
      door_open <= (state_n == ST_DOOR);
      fault     <= (state_n == ST_FAULT);
      disp_code <= disp_for(state_n, flr_n);
    end
  end

endmodule

// File: tb/tb_elevator_ctrl_3f.sv
// Directed bench for elevator_ctrl_3f with DOOR_CYCLES=4, TRAVEL_MAX=20.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
`timescale 1ns/1ps
module tb_elevator_ctrl_3f;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] call_btn;
  logic [2:0] flr_sens;
  logic       door_obst;
  logic       motor_up, motor_dn, door_open, fault;
  logic [2:0] disp_code;
  logic [2:0] dbg_state;
  logic [6:0] obs;
  logic       mon_en = 1'b0;

  int total = 0;
  int bad   = 0;

  // {fault, motor_up, motor_dn, door_open, disp_code}
  localparam logic [6:0] O_IDLE0 = 7'b0000000;
  localparam logic [6:0] O_IDLE1 = 7'b0000001;
  localparam logic [6:0] O_IDLE2 = 7'b0000010;
  localparam logic [6:0] O_DOOR0 = 7'b0001000;
  localparam logic [6:0] O_DOOR1 = 7'b0001001;
  localparam logic [6:0] O_DOOR2 = 7'b0001010;
  localparam logic [6:0] O_UP    = 7'b0100011;
  localparam logic [6:0] O_DN    = 7'b0010100;
  localparam logic [6:0] O_FLT   = 7'b1000111;

  localparam logic [2:0] S_IDLE = 3'd0, S_UP = 3'd1, S_DOWN = 3'd2, S_DOOR = 3'd3, S_FAULT = 3'd4;

  assign obs = {fault, motor_up, motor_dn, door_open, disp_code};

  elevator_ctrl_3f #(.DOOR_CYCLES(4), .TRAVEL_MAX(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .call_btn  (call_btn),
    .flr_sens  (flr_sens),
    .door_obst (door_obst),
    .motor_up  (motor_up),
    .motor_dn  (motor_dn),
    .door_open (door_open),
    .disp_code (disp_code),
    .fault     (fault),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Checker
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, land 1ns after the last.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [6:0] o, input logic [2:0] s);
    chk({tag, ".out"}, {25'd0, obs}, {25'd0, o});
    chk({tag, ".st"}, {29'd0, dbg_state}, {29'd0, s});
  endtask

  // Motor interlock and door/motor exclusion, checked every cycle once out of reset.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("invariant", {30'd0, motor_up & motor_dn, door_open & (motor_up | motor_dn)}, 32'd0);
    end
  end

  initial begin
    rst = 1'b1; call_btn = 3'b000; flr_sens = 3'b001; door_obst = 1'b0;
    tick(2);
    expect_st("reset", O_IDLE0, S_IDLE);
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: call at floor 0 opens the door for 4 cycles then idles.
    call_btn = 3'b001;
    tick(1);
    call_btn = 3'b000;
    expect_st("t1.latch", O_IDLE0, S_IDLE);
    tick(1);
    expect_st("t1.door1", O_DOOR0, S_DOOR);
    for (int i = 2; i <= 4; i++) begin
      tick(1);
      chk($sformatf("t1.door%0d", i), {31'd0, door_open}, 32'd1);
    end
    tick(1);
    expect_st("t1.close", O_IDLE0, S_IDLE);
    tick(3);
    expect_st("t1.req_clear", O_IDLE0, S_IDLE);

    // 2: call floor 2, pass floor 1, stop at floor 2.
    call_btn = 3'b100;
    tick(1);
    call_btn = 3'b000;
    tick(1);
    expect_st("t2.up", O_UP, S_UP);
    flr_sens = 3'b000;
    tick(1);
    flr_sens = 3'b010;
    tick(1);
    expect_st("t2.pass1", O_UP, S_UP);
    flr_sens = 3'b000;
    tick(1);
    expect_st("t2.between", O_UP, S_UP);
    flr_sens = 3'b100;
    tick(1);
    expect_st("t2.arrive2", O_DOOR2, S_DOOR);

    // 4: obstruction on the 3rd door cycle keeps it open 4 more cycles.
    tick(2);
    door_obst = 1'b1;
    tick(1);
    door_obst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t4.held%0d", i), {31'd0, door_open}, 32'd1);
      tick(1);
    end
    expect_st("t4.close", O_IDLE2, S_IDLE);

    // 3: calls at floors 0 and 1 from floor 2; stop at 1, continue to 0.
    call_btn = 3'b011;
    tick(1);
    call_btn = 3'b000;
    tick(1);
    expect_st("t3.down", O_DN, S_DOWN);
    tick(1);
    expect_st("t3.depart", O_DN, S_DOWN);
    flr_sens = 3'b010;
    tick(1);
    expect_st("t3.stop1", O_DOOR1, S_DOOR);
    tick(3);
    chk("t3.door1_last", {31'd0, door_open}, 32'd1);
    tick(1);
    expect_st("t3.idle1", O_IDLE1, S_IDLE);
    tick(1);
    expect_st("t3.resume", O_DN, S_DOWN);
    flr_sens = 3'b000;
    tick(1);
    flr_sens = 3'b001;
    tick(1);
    expect_st("t3.stop0", O_DOOR0, S_DOOR);
    tick(4);
    expect_st("t3.idle0", O_IDLE0, S_IDLE);

    // 5: conflicting sensors while travelling up -> sticky fault.
    call_btn = 3'b010;
    tick(1);
    call_btn = 3'b000;
    tick(1);
    expect_st("t5.up", O_UP, S_UP);
    flr_sens = 3'b110;
    tick(1);
    expect_st("t5.fault", O_FLT, S_FAULT);
    flr_sens = 3'b001;
    call_btn = 3'b111;
    tick(3);
    call_btn = 3'b000;
    expect_st("t5.sticky", O_FLT, S_FAULT);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expect_st("t5.reset", O_IDLE0, S_IDLE);

    // 6: no sensor for 20 cycles while travelling -> fault.
    call_btn = 3'b100;
    tick(1);
    call_btn = 3'b000;
    tick(1);
    expect_st("t6.up", O_UP, S_UP);
    flr_sens = 3'b000;
    tick(19);
    expect_st("t6.cycle20", O_UP, S_UP);
    tick(1);
    expect_st("t6.timeout", O_FLT, S_FAULT);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    flr_sens = 3'b001;
    expect_st("t6.reset", O_IDLE0, S_IDLE);

    // 7: sensor skips a floor in the travel direction -> fault.
    call_btn = 3'b100;
    tick(1);
    call_btn = 3'b000;
    tick(1);
    expect_st("t7.up", O_UP, S_UP);
    flr_sens = 3'b100;
    tick(1);
    expect_st("t7.skip", O_FLT, S_FAULT);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expect_st("t7.reset", O_IDLE0, S_IDLE);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
